// File: rtl/sm_run_ctrl_pkg.sv
// Shared run-control state encodings and widths. The encoding is also the status code.
package sm_run_ctrl_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    RC_HALT  = 2'b00,
    RC_RUN   = 2'b01,
    RC_STEP  = 2'b10,
    RC_BREAK = 2'b11
  } rc_state_t;

  function automatic logic rc_is_stopped(rc_state_t s);
    return (s == RC_HALT) || (s == RC_BREAK);
  endfunction

endpackage

// File: rtl/sm_run_ctrl_if.sv
// Debug-request / CPU-side signal bundle of the run controller.
// The tickCount/tickCountClr pair exists only when SM_RUN_CTRL_TICK_COUNT_EN is defined.
interface sm_run_ctrl_if;
  import sm_run_ctrl_pkg::*;

  logic                runReq;
  logic                stepReq;
  logic                haltReq;
  logic [3:0]          divide;
  logic                bpValid;
  logic [31:0]         bpAddr;
  logic [31:0]         pc;
  logic                tick;
  logic [STATUS_W-1:0] status;
  logic                halted;
`ifdef SM_RUN_CTRL_TICK_COUNT_EN
  logic                tickCountClr;
  logic [31:0]         tickCount;
`endif

  modport master (
    output runReq, stepReq, haltReq, divide, bpValid, bpAddr, pc,
`ifdef SM_RUN_CTRL_TICK_COUNT_EN
    output tickCountClr,
    input  tickCount,
`endif
    input  tick, status, halted
  );

  modport slave (
    input  runReq, stepReq, haltReq, divide, bpValid, bpAddr, pc,
`ifdef SM_RUN_CTRL_TICK_COUNT_EN
    input  tickCountClr,
    output tickCount,
`endif
    output tick, status, halted
  );

endinterface

// File: rtl/sm_edge_detect.sv
// Registered rising-edge detector for an already-synchronized level request.
// Latency: rise is combinational in the first cycle req is high.
// Backpressure: none; a held level yields exactly one event.
module sm_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rise
);

  logic req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_d <= 1'b0;
    else        req_d <= req;
  end

  assign rise = req & ~req_d;

endmodule

// File: rtl/sm_run_ctrl.sv
// CPU run-control sequencer producing a one-cycle clock-enable (tick); optional tick counter via SM_RUN_CTRL_TICK_COUNT_EN.
// Latency: step rise in cycle N gives tick in N+1; RUN ticks every 2^(SHIFT+divide) cycles.
// Backpressure: none; requests arriving while in STEP are dropped.
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int SHIFT     = 16,
  parameter bit RESET_RUN = 1'b1,
  parameter int CNT_W     = SHIFT + 16
) (
  input  logic          clkIn,
  input  logic          rst_n,
  sm_run_ctrl_if.slave  bus
);

  localparam rc_state_t RESET_STATE = RESET_RUN ? RC_RUN : RC_HALT;

  rc_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;
  logic             resume_q, resume_d;
  logic             run_ev, step_ev, halt_ev;
  logic             fire, bp_hit, tick_raw, tick;

  sm_edge_detect u_run_edge  (.clk(clkIn), .rst_n(rst_n), .req(bus.runReq),  .rise(run_ev));
  sm_edge_detect u_step_edge (.clk(clkIn), .rst_n(rst_n), .req(bus.stepReq), .rise(step_ev));
  sm_edge_detect u_halt_edge (.clk(clkIn), .rst_n(rst_n), .req(bus.haltReq), .rise(halt_ev));

  // Compare with >= so a shrinking divide fires at once and a growing one stretches the period.
  assign limit  = (CNT_W'(1) << (SHIFT + int'(bus.divide))) - CNT_W'(1);
  assign fire   = (cnt_q >= limit);
  assign bp_hit = bus.bpValid && (bus.pc == bus.bpAddr) && !resume_q;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      resume_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    tick_raw = 1'b0;
    case (state_q)
      RC_HALT, RC_BREAK: begin
        if (halt_ev) begin
          state_d = RC_HALT;
        end else if (run_ev) begin
          state_d  = RC_RUN;
          cnt_d    = '0;
          resume_d = 1'b1;
        end else if (step_ev) begin
          state_d = RC_STEP;
        end
      end
      RC_STEP: begin
        tick_raw = 1'b1;
        state_d  = RC_HALT;
      end
      RC_RUN: begin
        if (halt_ev) begin
          state_d = RC_HALT;
          cnt_d   = '0;
        end else begin
          if (fire) begin
            cnt_d    = '0;
            resume_d = 1'b0;
            if (bp_hit) state_d  = RC_BREAK;
            else        tick_raw = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (run_ev) cnt_d = '0;
        end
      end
    endcase
  end

  // Gate with reset so a zero-length period cannot strobe while reset is held.
  assign tick       = tick_raw & rst_n;
  assign bus.tick   = tick;
  assign bus.status = state_q;
  assign bus.halted = rc_is_stopped(state_q);

`ifdef SM_RUN_CTRL_TICK_COUNT_EN
  logic [31:0] tick_cnt_q;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n)                tick_cnt_q <= '0;
    else if (bus.tickCountClr) tick_cnt_q <= '0;
    else if (tick)             tick_cnt_q <= tick_cnt_q + 32'd1;
  end

  assign bus.tickCount = tick_cnt_q;
`endif

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Randomized bench for sm_run_ctrl: expectations queued per cycle by a behavioural model, checked by a monitor.
module tb_sm_run_ctrl;

  localparam int SHIFT = 0;

  typedef struct {
    logic        tick;
    logic [1:0]  status;
    logic        halted;
    logic [31:0] tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_run_ctrl_if rc ();

  sm_run_ctrl #(.SHIFT(SHIFT), .RESET_RUN(1'b1)) dut (
    .clkIn (clk),
    .rst_n (rst_n),
    .bus   (rc)
  );

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: mode uses the status codes (0 halt, 1 run, 2 step, 3 break).
  int unsigned m_mode, m_cnt;
  bit          m_resume, p_run, p_step, p_halt;
  logic [31:0] m_pc, m_tc;
  bit          clr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  task automatic model_reset();
    m_mode = 1; m_cnt = 0; m_resume = 1'b1;
    p_run = 1'b0; p_step = 1'b0; p_halt = 1'b0;
    m_pc = 32'h0; m_tc = 32'h0;
  endtask

  function automatic bit model_fires();
    return (m_mode == 1) && (m_cnt + 1 >= (32'd1 << (SHIFT + int'(rc.divide))));
  endfunction

  // Called at posedge+1 with this cycle's inputs set; models the cycle, then advances to the next one.
  task automatic run_cycle();
    exp_t e;
    bit re, se, he;
    rc.pc = m_pc;
`ifdef SM_RUN_CTRL_TICK_COUNT_EN
    rc.tickCountClr = clr;
`endif
    if (!rst_n) begin
      model_reset();
      e.tick = 1'b0; e.status = 2'd1; e.halted = 1'b0; e.tc = 32'h0;
      rc.pc = m_pc;
    end else begin
      re = rc.runReq  && !p_run;
      se = rc.stepReq && !p_step;
      he = rc.haltReq && !p_halt;
      p_run = rc.runReq; p_step = rc.stepReq; p_halt = rc.haltReq;
      e.status = m_mode[1:0];
      e.halted = (m_mode == 0) || (m_mode == 3);
      e.tick   = 1'b0;
      e.tc     = m_tc;
      if (m_mode == 2) begin
        e.tick = 1'b1;
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (he) begin
          m_mode = 0; m_cnt = 0;
        end else begin
          if (model_fires()) begin
            if (rc.bpValid && rc.pc == rc.bpAddr && !m_resume) m_mode = 3;
            else e.tick = 1'b1;
            m_resume = 1'b0;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
          if (re) m_cnt = 0;
        end
      end else begin
        if (he)      m_mode = 0;
        else if (re) begin m_mode = 1; m_cnt = 0; m_resume = 1'b1; end
        else if (se) m_mode = 2;
      end
      if (clr)         m_tc = 32'h0;
      else if (e.tick) m_tc = m_tc + 32'd1;
      if (e.tick) m_pc = (m_pc + 32'd4) & 32'h1F;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tick",   {31'd0, rc.tick},   {31'd0, e.tick});
        check("status", {30'd0, rc.status}, {30'd0, e.status});
        check("halted", {31'd0, rc.halted}, {31'd0, e.halted});
`ifdef SM_RUN_CTRL_TICK_COUNT_EN
        check("tickCount", rc.tickCount, e.tc);
`endif
      end
    end
  end

  initial begin : stim
    int guard;
    rc.runReq = 1'b0; rc.stepReq = 1'b0; rc.haltReq = 1'b0;
    rc.divide = 4'd2; rc.bpValid = 1'b0; rc.bpAddr = 32'h10; rc.pc = 32'h0;
    clr = 1'b0;
    model_reset();
    @(posedge clk); #1;
    repeat (3) run_cycle();
    rst_n = 1'b1;

    // Free run at period 4.
    repeat (20) run_cycle();

    // Halt landing on a fire cycle.
    guard = 0;
    while (!model_fires() && guard < 40) begin run_cycle(); guard++; end
    rc.haltReq = 1'b1;
    run_cycle();
    repeat (10) run_cycle();
    rc.haltReq = 1'b0;
    repeat (40) run_cycle();

    // Single step with a held request.
    rc.stepReq = 1'b1;
    repeat (10) run_cycle();
    rc.stepReq = 1'b0;
    repeat (3) run_cycle();

    // Breakpoint at 0x10, resumed several times.
    rc.bpValid = 1'b1; rc.bpAddr = 32'h10;
    for (int round = 0; round < 3; round++) begin
      rc.runReq = 1'b1; run_cycle();
      rc.runReq = 1'b0; run_cycle();
      guard = 0;
      while (m_mode != 3 && guard < 400) begin run_cycle(); guard++; end
      check("bp_reached", {31'd0, (m_mode == 3)}, 32'd1);
      repeat (3) run_cycle();
    end

    // Divide shrink 4 -> 1 with counter at 9.
    rc.bpValid = 1'b0; rc.divide = 4'd4;
    rc.runReq = 1'b1; run_cycle();
    rc.runReq = 1'b0;
    guard = 0;
    while (m_cnt != 9 && guard < 40) begin run_cycle(); guard++; end
    rc.divide = 4'd1;
    repeat (10) run_cycle();

    // Coincident events from HALT, then counter clear.
    rc.haltReq = 1'b1; run_cycle();
    rc.haltReq = 1'b0; repeat (2) run_cycle();
    rc.runReq = 1'b1; rc.stepReq = 1'b1; rc.haltReq = 1'b1;
    repeat (4) run_cycle();
    rc.runReq = 1'b0; rc.stepReq = 1'b0; rc.haltReq = 1'b0;
    repeat (2) run_cycle();
    clr = 1'b1; run_cycle();
    clr = 1'b0; repeat (2) run_cycle();

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rc.runReq  = ~rc.runReq;
      if ($urandom_range(0, 19) == 0) rc.stepReq = ~rc.stepReq;
      if ($urandom_range(0, 29) == 0) rc.haltReq = ~rc.haltReq;
      rc.divide = 4'($urandom_range(0, 2));
      if (i % 50 == 0) begin
        rc.bpValid = 1'($urandom_range(0, 1));
        rc.bpAddr  = ($urandom_range(0, 1) != 0) ? 32'h10 : 32'h08;
      end
      clr   = ($urandom_range(0, 199) == 0);
      rst_n = !(i == 1500 || i == 1501);
      run_cycle();
    end
    rst_n = 1'b1;
    clr   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
